// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared core widths, register-address constants and datapath typedefs
package riscv_pkg;

   localparam int XLEN   = 32;
   localparam int NREGS  = 32;
   localparam int REG_AW = $clog2(NREGS);

   typedef logic [XLEN-1:0]   xlen_t;
   typedef logic [REG_AW-1:0] reg_addr_t;

   localparam reg_addr_t REG_ZERO = 5'd0;

endpackage

// File: rtl/wb_regfile_if.sv
// rtl/wb_regfile_if.sv - MEM/WB writeback, ID read-port and forwarding signal bundle
interface wb_regfile_if #(
   parameter int CNT_W = 32
);
   import riscv_pkg::*;

   xlen_t             memwb_ula_result;
   xlen_t             memwb_mem_data;
   reg_addr_t         memwb_rd;
   logic              memwb_RegWrite;
   logic              memwb_MemtoReg;
   reg_addr_t         rs1_addr;
   reg_addr_t         rs2_addr;
   xlen_t             rs1_data;
   xlen_t             rs2_data;
   logic              wb_we;
   reg_addr_t         wb_rd;
   xlen_t             wb_data;
   logic [CNT_W-1:0]  retire_cnt;

   modport master (
      output memwb_ula_result, memwb_mem_data, memwb_rd, memwb_RegWrite, memwb_MemtoReg,
      output rs1_addr, rs2_addr,
      input  rs1_data, rs2_data, wb_we, wb_rd, wb_data, retire_cnt
   );

   modport slave (
      input  memwb_ula_result, memwb_mem_data, memwb_rd, memwb_RegWrite, memwb_MemtoReg,
      input  rs1_addr, rs2_addr,
      output rs1_data, rs2_data, wb_we, wb_rd, wb_data, retire_cnt
   );

endinterface

// File: rtl/regfile_2r1w.sv
// rtl/regfile_2r1w.sv - 32-entry register array, one write port, two write-first read ports
module regfile_2r1w
   import riscv_pkg::*;
(
   input  logic      clk,
   input  logic      rst,
   input  logic      we,
   input  reg_addr_t waddr,
   input  xlen_t     wdata,
   input  reg_addr_t raddr1,
   input  reg_addr_t raddr2,
   output xlen_t     rdata1,
   output xlen_t     rdata2
);

   xlen_t regs [NREGS];

   // Entry 0 is never written, so it stays at its reset value of zero.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NREGS; i++) begin
            regs[i] <= '0;
         end
      end else if (we && (waddr != REG_ZERO)) begin
         regs[waddr] <= wdata;
      end
   end

   always_comb begin
      rdata1 = regs[raddr1];
      if (raddr1 == REG_ZERO) begin
         rdata1 = '0;
      end else if (we && (raddr1 == waddr)) begin
         rdata1 = wdata;
      end
   end

   always_comb begin
      rdata2 = regs[raddr2];
      if (raddr2 == REG_ZERO) begin
         rdata2 = '0;
      end else if (we && (raddr2 == waddr)) begin
         rdata2 = wdata;
      end
   end

endmodule

// File: rtl/wb_regfile.sv
// rtl/wb_regfile.sv - writeback select, register-file commit and retired-write counter
module wb_regfile
   import riscv_pkg::*;
#(
   parameter int CNT_W = 32
) (
   input  logic          clk,
   input  logic          rst,
   wb_regfile_if.slave   bus
);

   xlen_t            wb_data;
   logic             wb_we;
   logic [CNT_W-1:0] cnt_q;

   assign wb_data = bus.memwb_MemtoReg ? bus.memwb_mem_data : bus.memwb_ula_result;
   // Writes to x0 are dropped here so they neither commit nor count.
   assign wb_we   = bus.memwb_RegWrite && (bus.memwb_rd != REG_ZERO);

   assign bus.wb_data    = wb_data;
   assign bus.wb_we      = wb_we;
   assign bus.wb_rd      = bus.memwb_rd;
   assign bus.retire_cnt = cnt_q;

   regfile_2r1w u_regs (
      .clk    (clk),
      .rst    (rst),
      .we     (wb_we),
      .waddr  (bus.memwb_rd),
      .wdata  (wb_data),
      .raddr1 (bus.rs1_addr),
      .raddr2 (bus.rs2_addr),
      .rdata1 (bus.rs1_data),
      .rdata2 (bus.rs2_data)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
      end else if (wb_we) begin
         cnt_q <= cnt_q + 1'b1;
      end
   end

endmodule

// File: tb/tb_wb_regfile.sv
// tb/tb_wb_regfile.sv - randomized and directed bench for wb_regfile against an array model
module tb_wb_regfile;

   logic clk;
   logic rst;
   int   checks;
   int   failures;

   logic [31:0] mregs [32];
   int unsigned mcnt;

   wb_regfile_if #(.CNT_W(32)) bus ();
   wb_regfile_if #(.CNT_W(4))  bus4 ();

   wb_regfile #(.CNT_W(32)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   wb_regfile #(.CNT_W(4)) dut4 (
      .clk (clk),
      .rst (rst),
      .bus (bus4)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] exp_read(input logic [4:0] a, input logic wev,
                                            input logic [4:0] rd, input logic [31:0] wbv);
      if (a == 5'd0) return 32'd0;
      if (wev && a == rd) return wbv;
      return mregs[a];
   endfunction

   task automatic step(input logic r, input logic we, input logic mt, input logic [4:0] rd,
                       input logic [31:0] ula, input logic [31:0] mem,
                       input logic [4:0] a1, input logic [4:0] a2);
      logic [31:0] wbv;
      logic        wev;
      @(negedge clk);
      rst                  = r;
      bus.memwb_RegWrite   = we;
      bus.memwb_MemtoReg   = mt;
      bus.memwb_rd         = rd;
      bus.memwb_ula_result = ula;
      bus.memwb_mem_data   = mem;
      bus.rs1_addr         = a1;
      bus.rs2_addr         = a2;
      if (r) begin
         for (int i = 0; i < 32; i++) mregs[i] = 32'd0;
         mcnt = 0;
      end
      wbv = mt ? mem : ula;
      wev = we && (rd != 5'd0);
      #1;
      chk("rs1_data", bus.rs1_data, exp_read(a1, wev, rd, wbv));
      chk("rs2_data", bus.rs2_data, exp_read(a2, wev, rd, wbv));
      chk("wb_data", bus.wb_data, wbv);
      chk("wb_we", {31'd0, bus.wb_we}, {31'd0, wev});
      chk("wb_rd", {27'd0, bus.wb_rd}, {27'd0, rd});
      chk("retire_cnt", bus.retire_cnt, mcnt);
      @(posedge clk);
      if (!r && wev) begin
         mregs[rd] = wbv;
         mcnt++;
      end
   endtask

   initial begin
      logic [31:0] last;
      logic [4:0]  rd, a1, a2;
      checks   = 0;
      failures = 0;
      mcnt     = 0;
      for (int i = 0; i < 32; i++) mregs[i] = 32'd0;
      rst = 1'b1;
      bus.memwb_RegWrite = 1'b0;  bus.memwb_MemtoReg = 1'b0;  bus.memwb_rd = '0;
      bus.memwb_ula_result = '0;  bus.memwb_mem_data = '0;
      bus.rs1_addr = '0;          bus.rs2_addr = '0;
      bus4.memwb_RegWrite = 1'b0; bus4.memwb_MemtoReg = 1'b0; bus4.memwb_rd = '0;
      bus4.memwb_ula_result = '0; bus4.memwb_mem_data = '0;
      bus4.rs1_addr = '0;         bus4.rs2_addr = '0;

      // reset held two cycles, then sweep every address on both ports
      step(1'b1, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0, 5'd0, 5'd0);
      step(1'b1, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0, 5'd0, 5'd0);
      for (int a = 0; a < 32; a++) begin
         step(1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0, 5'(a), 5'(31 - a));
      end

      // ALU write with same-cycle bypass, then hold
      step(1'b0, 1'b1, 1'b0, 5'd5, 32'hDEADBEEF, 32'h0, 5'd5, 5'd0);
      chk("t2_bypass_const", bus.rs1_data, 32'hDEADBEEF);
      step(1'b0, 1'b0, 1'b0, 5'd5, 32'h0, 32'h0, 5'd5, 5'd5);
      chk("t2_hold_const", bus.rs1_data, 32'hDEADBEEF);
      chk("t2_cnt_const", bus.retire_cnt, 32'd1);

      // load write, both ports bypassed
      step(1'b0, 1'b1, 1'b1, 5'd7, 32'hFFFFFFFF, 32'h12345678, 5'd7, 5'd7);

      // x0 write is dropped
      step(1'b0, 1'b1, 1'b0, 5'd0, 32'hAAAA5555, 32'h0, 5'd0, 5'd0);
      chk("t4_cnt_const", bus.retire_cnt, 32'd2);
      step(1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 5'd0, 5'd7);

      // reset arriving together with a write
      step(1'b0, 1'b1, 1'b0, 5'd3, 32'h11, 32'h0, 5'd3, 5'd3);
      step(1'b1, 1'b1, 1'b0, 5'd3, 32'h22, 32'h0, 5'd3, 5'd5);
      step(1'b0, 1'b0, 1'b0, 5'd3, 32'h0, 32'h0, 5'd3, 5'd5);
      chk("t5_x3_const", bus.rs1_data, 32'd0);
      chk("t5_cnt_const", bus.retire_cnt, 32'd0);

      // randomized traffic
      for (int n = 0; n < 300; n++) begin
         rd = 5'($urandom_range(0, 31));
         a1 = ($urandom_range(0, 1) == 0) ? rd : 5'($urandom_range(0, 31));
         a2 = ($urandom_range(0, 2) == 0) ? rd : 5'($urandom_range(0, 31));
         step(1'b0, ($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), rd,
              $urandom, $urandom, a1, a2);
      end

      // narrow counter wraps after 16 commits
      last = 32'd0;
      for (int i = 0; i < 17; i++) begin
         @(negedge clk);
         last = $urandom;
         bus4.memwb_RegWrite   = 1'b1;
         bus4.memwb_rd         = 5'd1;
         bus4.memwb_ula_result = last;
         #1;
         chk("wrap_cnt", {28'd0, bus4.retire_cnt}, 32'(i % 16));
         @(posedge clk);
      end
      @(negedge clk);
      bus4.memwb_RegWrite = 1'b0;
      bus4.rs1_addr       = 5'd1;
      #1;
      chk("wrap_final_cnt", {28'd0, bus4.retire_cnt}, 32'd1);
      chk("wrap_x1", bus4.rs1_data, last);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
